fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch sequencer sitting directly upstream of the 15-bit PC register.
- Produces the PC register's next value and write enable, and issues one instruction-memory read per PC.
- Buffers returned instructions in a 2-entry queue toward decode.
- Handles branch/jump redirects, discarding stale in-flight and buffered instructions.

Parameters:
- N, 15, PC/instruction-address width (word address).
- W, 16, instruction width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-high reset (1 = reset, despite the suffix).
- pc_in  in  N  current PC, from the PC register output.
- pc_next  out  N  value to load into the PC register.
- pc_we  out  1  PC register write enable.
- imem_req_valid  out  1  instruction-memory read request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  N  request address; always equals pc_in.
- imem_resp_valid  in  1  read data valid (one response per accepted request, in order, at least 1 cycle later).
- imem_resp_data  in  W  instruction word.
- redirect_valid  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc  in  N  redirect target.
- halt  in  1  level; blocks new requests.
- dec_valid  out  1  buffer head valid.
- dec_ready  in  1  decode consumes head.
- dec_instr  out  W  head instruction.
- dec_pc  out  N  PC of head instruction.

Behaviour:
- **Reset:** asynchronous, active-high. While reset_n=1:
  - state=REQ, buffer count=0, squash=0.
  - dec_valid=0, dec_instr=0, dec_pc=0, imem_req_valid=0, pc_we=0, pc_next=0.
- **FSM states:** REQ, WAIT, HOLD.
- **Request issue:**
  - imem_req_valid = (state==REQ) & !redirect_valid & !halt & (count<2).
  - Handshake = imem_req_valid & imem_req_ready.
  - On handshake: latch pc_in as pend_pc; pc_we=1; pc_next=pc_in+1 (mod 2^N; 0x7FFF wraps to 0x0000); go WAIT.
  - First fetch after reset uses address 0.
- **REQ without handshake:** stay in REQ; pc_we=0.
- **WAIT:**
  - On imem_resp_valid with squash=0: push {imem_resp_data, pend_pc}.
  - Then go to HOLD if the post-push count is 2, else REQ.
  - On imem_resp_valid with squash=1: drop the response, clear squash, go REQ.
- **HOLD:** go REQ when count<2 (i.e. after a pop).
- **Redirect** (highest priority, any state):
  - pc_we=1, pc_next=redirect_pc that cycle; imem_req_valid forced 0.
  - Buffer flushed, count=0, dec_valid=0 next cycle. A pop in the same cycle is ignored.
  - In WAIT with no response this cycle: set squash=1, stay WAIT.
  - In WAIT with a response this cycle: drop it, go REQ, squash stays 0.
  - In HOLD: go REQ.
- **Redirect + squash=1 pending:** squash stays 1 (one outstanding request max).
- **Buffer:**
  - 2-entry FIFO, in-order; dec_* reflect the head registered value, 0-cycle read.
  - Pop = dec_valid & dec_ready.
  - Push and pop in the same cycle keep count unchanged.
  - Push never occurs when full (issue requires count<2).
- **halt:** only gates new requests. An outstanding response still completes and is pushed; redirect is still honoured.
- **Latency:** request-accept to dec_valid = memory latency + 1 cycle. Peak throughput is one instruction every 2 cycles for 1-cycle memory.
- **At most one outstanding memory request at any time.**

Decomposition:
- Shared package holds:
  - FETCH_REQ/FETCH_WAIT/FETCH_HOLD state encodings (2 bits).
  - Default N=15 and W=16 constants.
  - The fetch-entry record {instr, pc}.
- One natural sub-module: fetch_queue (2-entry FIFO with flush, push, pop, count, head outputs).

Test Plan:
- **Reset release, mem ready=1, 1-cycle latency, dec_ready=1:** requests at 0, 1, 2; pc_next=1, 2, 3 with pc_we pulses; dec_pc sequence 0, 1, 2 with matching data.
- **dec_ready=0 for 10 cycles:** exactly 2 entries buffered (PC 0, 1), FSM in HOLD, no request. Raise dec_ready → request for PC 2 issued within 2 cycles.
- **Redirect to 0x0100 while in WAIT for PC 5:** response for PC 5 dropped; next request address 0x0100; dec_pc of next delivered instruction is 0x0100. Buffered entries flushed.
- **Redirect coinciding with the response cycle:** response dropped, squash=0, next request at the target the following cycle.
- **pc_in=0x7FFF handshake:** pc_next=0x0000.
- **halt=1 during WAIT:** response still delivered, no further requests. Assert reset_n mid-WAIT → all outputs 0 immediately (asynchronous); a late memory response after release is not pushed.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: fetch sequencer state encodings, default widths and the queued entry record
package fetch_unit_pkg;
  localparam int N_DEF = 15;
  localparam int W_DEF = 16;
  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_t;
  typedef struct packed {
    logic [W_DEF-1:0] instr;
    logic [N_DEF-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry in-order instruction buffer with flush; head is visible combinationally
module fetch_queue import fetch_unit_pkg::*; #(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_instr,
  input  logic [N-1:0] push_pc,
  output logic [1:0]   count,
  output logic         valid,
  output logic [W-1:0] head_instr,
  output logic [N-1:0] head_pc
);
  logic [W-1:0] instr [2];
  logic [N-1:0] pc [2];
  logic slot;
  assign valid = count != 2'd0;
  assign head_instr = instr[0];
  assign head_pc = pc[0];
  // entry 0 is always the head, so a pop shifts entry 1 down and the write slot moves with it
  assign slot = pop ? count == 2'd2 : count == 2'd1;
  always_ff @(posedge clk or posedge reset_n)
    if (reset_n) begin
      count <= 2'd0;
      instr <= '{default: '0};
      pc <= '{default: '0};
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        instr[0] <= instr[1];
        pc[0] <= pc[1];
      end
      if (push) begin
        instr[slot] <= push_instr;
        pc[slot] <= push_pc;
      end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: drives the PC register, issues one imem read per PC and buffers returns toward decode
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] pc_in,
  output logic [N-1:0] pc_next,
  output logic         pc_we,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [N-1:0] imem_req_addr,
  input  logic         imem_resp_valid,
  input  logic [W-1:0] imem_resp_data,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  input  logic         halt,
  output logic         dec_valid,
  input  logic         dec_ready,
  output logic [W-1:0] dec_instr,
  output logic [N-1:0] dec_pc
);
  fetch_state_t state, state_nx;
  logic squash, squash_nx, hs, push, pop;
  logic [N-1:0] pend_pc;
  logic [1:0] count;
  assign imem_req_addr = pc_in;
  assign imem_req_valid = !reset_n && state == FETCH_REQ && !redirect_valid && !halt && count < 2'd2;
  assign hs = imem_req_valid && imem_req_ready;
  assign pop = dec_valid && dec_ready && !redirect_valid;
  assign push = state == FETCH_WAIT && imem_resp_valid && !squash && !redirect_valid;
  assign pc_we = !reset_n && (redirect_valid || hs);
  assign pc_next = reset_n ? '0 : redirect_valid ? redirect_pc : pc_in + N'(1);
  always_comb begin
    state_nx = state;
    squash_nx = squash;
    case (state)
      FETCH_REQ: state_nx = hs ? FETCH_WAIT : FETCH_REQ;
      FETCH_WAIT: begin
        state_nx = !imem_resp_valid ? FETCH_WAIT :
                   (push && !pop && count == 2'd1) ? FETCH_HOLD : FETCH_REQ;
        // a redirect while the read is still out marks its eventual response as stale
        squash_nx = imem_resp_valid ? 1'b0 : squash || redirect_valid;
      end
      FETCH_HOLD: state_nx = (redirect_valid || pop) ? FETCH_REQ : FETCH_HOLD;
      default: state_nx = FETCH_REQ;
    endcase
  end
  always_ff @(posedge clk or posedge reset_n)
    if (reset_n) begin
      state <= FETCH_REQ;
      squash <= 1'b0;
      pend_pc <= '0;
    end else begin
      state <= state_nx;
      squash <= squash_nx;
      if (hs) pend_pc <= pc_in;
    end
  fetch_queue #(.N(N), .W(W)) u_queue (
    .clk(clk),
    .reset_n(reset_n),
    .flush(redirect_valid),
    .push(push),
    .pop(pop),
    .push_instr(imem_resp_data),
    .push_pc(pend_pc),
    .count(count),
    .valid(dec_valid),
    .head_instr(dec_instr),
    .head_pc(dec_pc)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random fetch scenarios against a program-order delivery model
module tb_fetch_unit;
  localparam int N = 15;
  localparam int W = 16;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [N-1:0] pc_in, pc_next, imem_req_addr, redirect_pc, dec_pc;
  logic pc_we, imem_req_valid, imem_req_ready, imem_resp_valid, redirect_valid, halt, dec_valid, dec_ready;
  logic [W-1:0] imem_resp_data, dec_instr;
  int checks = 0, errors = 0;
  bit busy = 0;
  int wcnt = 0, lat_fix = 1, cyc_no = 0, n_hs = 0, n_pop = 0;
  bit rdy_rand = 0, hs, pop;
  logic [N-1:0] baddr, ep, erq;
  logic [N-1:0] hs_a [16], hs_nx [16], pop_p [16];
  int hs_c [16], pop_c [16];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .pc_in(pc_in), .pc_next(pc_next), .pc_we(pc_we),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc)
  );

  // the PC register the fetch unit sits in front of
  always_ff @(posedge clk or posedge reset_n)
    if (reset_n) pc_in <= '0;
    else if (pc_we) pc_in <= pc_next;

  function automatic logic [W-1:0] memf(input logic [N-1:0] a);
    return {1'b1, a} ^ 16'hC3A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_log();
    n_hs = 0;
    n_pop = 0;
    foreach (hs_a[i]) begin
      hs_a[i] = '1;
      hs_nx[i] = '1;
      pop_p[i] = '1;
      hs_c[i] = -100;
      pop_c[i] = -100;
    end
  endtask

  task automatic cyc(input logic rv, input logic [N-1:0] rpc, input logic h, input logic dr);
    logic [N-1:0] nxt;
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc = rpc;
    halt = h;
    dec_ready = dr;
    imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    imem_resp_valid = busy && wcnt == 0;
    imem_resp_data = imem_resp_valid ? memf(baddr) : W'($urandom);
    #1;
    hs = imem_req_valid && imem_req_ready;
    pop = dec_valid && dec_ready && !rv;
    nxt = erq + 15'd1;
    chk("req_addr_is_pc", 32'(imem_req_addr), 32'(pc_in));
    if (h) chk("halt_no_req", 32'(imem_req_valid), 32'd0);
    if (rv) begin
      chk("redir_we", 32'(pc_we), 32'd1);
      chk("redir_next", 32'(pc_next), 32'(rpc));
      chk("redir_no_req", 32'(imem_req_valid), 32'd0);
    end else if (hs) begin
      chk("req_pc", 32'(imem_req_addr), 32'(erq));
      chk("req_next", 32'(pc_next), 32'(nxt));
      chk("req_we", 32'(pc_we), 32'd1);
      chk("req_while_busy", 32'(busy), 32'd0);
    end else begin
      chk("idle_we", 32'(pc_we), 32'd0);
    end
    if (pop) begin
      chk("dec_pc", 32'(dec_pc), 32'(ep));
      chk("dec_instr", 32'(dec_instr), 32'(memf(ep)));
      ep = ep + 15'd1;
    end
    if (rv) begin
      ep = rpc;
      erq = rpc;
    end else if (hs) erq = nxt;
    if (imem_resp_valid) busy = 0;
    else if (busy) wcnt--;
    if (hs) begin
      busy = 1;
      baddr = imem_req_addr;
      wcnt = lat_fix == 0 ? int'($urandom_range(0, 2)) : lat_fix - 1;
    end
    if (hs) begin
      if (n_hs < 16) begin
        hs_a[n_hs] = imem_req_addr;
        hs_nx[n_hs] = pc_next;
        hs_c[n_hs] = cyc_no;
      end
      n_hs++;
    end
    if (pop) begin
      if (n_pop < 16) begin
        pop_p[n_pop] = dec_pc;
        pop_c[n_pop] = cyc_no;
      end
      n_pop++;
    end
    cyc_no++;
  endtask

  task automatic do_reset(input bit keep);
    @(negedge clk);
    redirect_valid = 1'b0;
    halt = 1'b1;
    dec_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_req_ready = 1'b1;
    reset_n = 1'b1;
    #1;
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_instr", 32'(dec_instr), 32'd0);
    chk("rst_dec_pc", 32'(dec_pc), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_pc_we", 32'(pc_we), 32'd0);
    chk("rst_pc_next", 32'(pc_next), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    ep = '0;
    erq = '0;
    if (!keep) busy = 0;
  endtask

  initial begin
    int raise;
    bit prev_rv;
    logic rv;
    redirect_valid = 1'b1;
    redirect_pc = 15'h1234;
    halt = 1'b0;
    dec_ready = 1'b0;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    #1 reset_n = 1'b1;
    #1;
    chk("init_pc_we", 32'(pc_we), 32'd0);
    chk("init_pc_next", 32'(pc_next), 32'd0);
    chk("init_req_valid", 32'(imem_req_valid), 32'd0);
    chk("init_dec_valid", 32'(dec_valid), 32'd0);
    redirect_valid = 1'b0;
    do_reset(1'b0);

    // streaming with 1-cycle memory and an always-ready decoder
    lat_fix = 1;
    clr_log();
    for (int i = 0; i < 8; i++) cyc(0, '0, 0, 1);
    chk("t1_hs_count", 32'(n_hs), 32'd4);
    chk("t1_hs0", 32'(hs_a[0]), 32'd0);
    chk("t1_hs1", 32'(hs_a[1]), 32'd1);
    chk("t1_hs2", 32'(hs_a[2]), 32'd2);
    chk("t1_next0", 32'(hs_nx[0]), 32'd1);
    chk("t1_next1", 32'(hs_nx[1]), 32'd2);
    chk("t1_next2", 32'(hs_nx[2]), 32'd3);
    chk("t1_pop0", 32'(pop_p[0]), 32'd0);
    chk("t1_pop1", 32'(pop_p[1]), 32'd1);
    chk("t1_pop2", 32'(pop_p[2]), 32'd2);
    chk("t1_latency", 32'(pop_c[0] - hs_c[0]), 32'd2);
    chk("t1_interval", 32'(pop_c[1] - pop_c[0]), 32'd2);

    // decoder stalled: two entries fill the buffer and requests stop
    do_reset(1'b0);
    clr_log();
    for (int i = 0; i < 10; i++) cyc(0, '0, 0, 0);
    chk("t2_hs_count", 32'(n_hs), 32'd2);
    chk("t2_dec_valid", 32'(dec_valid), 32'd1);
    chk("t2_dec_pc", 32'(dec_pc), 32'd0);
    chk("t2_dec_instr", 32'(dec_instr), 32'(memf(15'd0)));
    chk("t2_no_req", 32'(imem_req_valid), 32'd0);
    clr_log();
    raise = cyc_no;
    for (int i = 0; i < 4; i++) cyc(0, '0, 0, 1);
    chk("t2_pop0", 32'(pop_p[0]), 32'd0);
    chk("t2_pop1", 32'(pop_p[1]), 32'd1);
    chk("t2_pop_first", 32'(pop_c[0] - raise), 32'd0);
    chk("t2_back_to_back", 32'(pop_c[1] - pop_c[0]), 32'd1);
    chk("t2_hs_pc2", 32'(hs_a[0]), 32'd2);
    chk("t2_hs_delay", 32'(n_hs > 0 && hs_c[0] - raise <= 2), 32'd1);

    // redirect while waiting on PC 5
    for (int i = 0; i < 30 && pc_in != 15'd5; i++) cyc(0, '0, 0, 1);
    chk("t3_reach_pc5", 32'(pc_in), 32'd5);
    lat_fix = 3;
    clr_log();
    for (int i = 0; i < 10 && n_hs == 0; i++) cyc(0, '0, 0, 0);
    chk("t3_hs_pc5", 32'(hs_a[0]), 32'd5);
    chk("t3_buffered", 32'(dec_valid), 32'd1);
    cyc(1, 15'h0100, 0, 0);
    cyc(0, '0, 0, 0);
    chk("t3_flushed", 32'(dec_valid), 32'd0);
    lat_fix = 1;
    clr_log();
    for (int i = 0; i < 10; i++) cyc(0, '0, 0, 1);
    chk("t3_hs_target", 32'(hs_a[0]), 32'h0100);
    chk("t3_pop_target", 32'(pop_p[0]), 32'h0100);

    // redirect in the same cycle the response returns
    lat_fix = 2;
    clr_log();
    for (int i = 0; i < 10 && n_hs == 0; i++) cyc(0, '0, 0, 1);
    cyc(0, '0, 0, 1);
    cyc(1, 15'h02A0, 0, 1);
    lat_fix = 1;
    clr_log();
    cyc(0, '0, 0, 1);
    chk("t4_hs_next_cycle", 32'(n_hs), 32'd1);
    chk("t4_hs_target", 32'(hs_a[0]), 32'h02A0);
    for (int i = 0; i < 6; i++) cyc(0, '0, 0, 1);
    chk("t4_pop_target", 32'(pop_p[0]), 32'h02A0);

    // PC wrap at the top of the address space
    clr_log();
    cyc(1, 15'h7FFF, 0, 1);
    for (int i = 0; i < 20 && n_hs < 2; i++) cyc(0, '0, 0, 1);
    chk("t5_hs_top", 32'(hs_a[0]), 32'h7FFF);
    chk("t5_next_wrap", 32'(hs_nx[0]), 32'd0);
    chk("t5_hs_wrapped", 32'(hs_a[1]), 32'd0);
    for (int i = 0; i < 6; i++) cyc(0, '0, 0, 1);

    // halt while waiting, then asynchronous reset with a read still out
    do_reset(1'b0);
    lat_fix = 2;
    clr_log();
    for (int i = 0; i < 10 && n_hs == 0; i++) cyc(0, '0, 0, 0);
    clr_log();
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0);
    chk("t6_halt_no_hs", 32'(n_hs), 32'd0);
    chk("t6_halt_delivered", 32'(dec_valid), 32'd1);
    chk("t6_halt_pc", 32'(dec_pc), 32'd0);
    lat_fix = 4;
    clr_log();
    cyc(0, '0, 0, 0);
    chk("t6_second_hs", 32'(n_hs), 32'd1);
    cyc(0, '0, 1, 0);
    do_reset(1'b1);
    clr_log();
    for (int i = 0; i < 6; i++) cyc(0, '0, 1, 1);
    chk("t6_late_not_pushed", 32'(dec_valid), 32'd0);
    chk("t6_late_no_pop", 32'(n_pop), 32'd0);
    lat_fix = 1;
    clr_log();
    for (int i = 0; i < 8; i++) cyc(0, '0, 0, 1);
    chk("t6_restart_hs", 32'(hs_a[0]), 32'd0);
    chk("t6_restart_pop", 32'(pop_p[0]), 32'd0);

    // random traffic: latency, memory ready, decode ready, halt and redirects
    lat_fix = 0;
    rdy_rand = 1;
    prev_rv = 0;
    clr_log();
    for (int i = 0; i < 800; i++) begin
      rv = !prev_rv && $urandom_range(0, 19) == 0;
      cyc(rv, $urandom_range(0, 3) == 0 ? 15'h7FFE : N'($urandom), $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) != 0);
      prev_rv = rv;
    end
    chk("rand_progress", 32'(n_pop > 60), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
